// File: rtl/multi_clk_divider_if.sv
// Control/status bundle for the multi-channel clock divider.
// Master drives enables, sync and loads; slave returns clocks and ticks.
interface multi_clk_divider_if #(
  parameter int CNT_W  = 26,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic              load_en;
  logic [CH_W-1:0]   load_ch;
  logic [CNT_W-1:0]  load_val;
  logic [NUM_CH-1:0] divided_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  modport master (
    output ch_en,
    output sync,
    output load_en,
    output load_ch,
    output load_val,
    input  divided_clk,
    input  tick,
    input  pending
  );

  modport slave (
    input  ch_en,
    input  sync,
    input  load_en,
    input  load_ch,
    input  load_val,
    output divided_clk,
    output tick,
    output pending
  );
endinterface

// File: rtl/multi_clk_divider.sv
// NUM_CH independent clk_in dividers with shadowed terminal counts,
// per-channel enable and a global phase-align sync.
module multi_clk_divider #(
  parameter int          CNT_W       = 26,
  parameter int          NUM_CH      = 4,
  parameter int          CH_W        = 2,
  parameter int unsigned DIV_DEFAULT = 19999999
) (
  input logic                clk_in,
  input logic                rst,
  multi_clk_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

  logic [NUM_CH-1:0] w_div;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_div;
    logic             r_tick;
    logic             r_pend;
    logic             w_ld;
    logic             w_wrap;
    logic             w_hold;
    logic [CNT_W-1:0] w_commit;

    // load_ch beyond NUM_CH-1 never matches any channel
    assign w_ld     = bus.load_en && (bus.load_ch == CH_W'(g));
    assign w_wrap   = (r_cnt == r_active);
    assign w_hold   = bus.sync || !bus.ch_en[g];
    // a load in a commit cycle bypasses the shadow
    assign w_commit = w_ld ? bus.load_val : r_shadow;

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        r_cnt    <= '0;
        r_active <= DIV_RST;
        r_shadow <= DIV_RST;
        r_div    <= 1'b0;
        r_tick   <= 1'b0;
        r_pend   <= 1'b0;
      end else if (w_hold) begin
        r_cnt    <= '0;
        r_active <= w_commit;
        r_shadow <= w_commit;
        r_div    <= 1'b0;
        r_tick   <= 1'b0;
        r_pend   <= 1'b0;
      end else if (w_wrap) begin
        r_cnt    <= '0;
        r_active <= w_commit;
        r_shadow <= w_commit;
        r_div    <= ~r_div;
        r_tick   <= 1'b1;
        r_pend   <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
        if (w_ld) begin
          r_shadow <= bus.load_val;
          r_pend   <= 1'b1;
        end
      end
    end

    assign w_div[g]  = r_div;
    assign w_tick[g] = r_tick;
    assign w_pend[g] = r_pend;
  end

  assign bus.divided_clk = w_div;
  assign bus.tick        = w_tick;
  assign bus.pending     = w_pend;

endmodule

// File: tb/tb_multi_clk_divider.sv
// Directed bench for multi_clk_divider: reload, bypass, T=0,
// enable, sync, ignored load and async reset.
module tb_multi_clk_divider;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  int n_chk = 0;
  int n_bad = 0;

  multi_clk_divider_if #(.CNT_W(8), .NUM_CH(2), .CH_W(1)) bus ();
  multi_clk_divider_if #(.CNT_W(8), .NUM_CH(3), .CH_W(2)) bus3 ();

  multi_clk_divider #(
    .CNT_W(8), .NUM_CH(2), .CH_W(1), .DIV_DEFAULT(3)
  ) u_dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  multi_clk_divider #(
    .CNT_W(8), .NUM_CH(3), .CH_W(2), .DIV_DEFAULT(3)
  ) u_dut3 (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus3)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input logic ch, input logic [7:0] v);
    bus.load_en  = 1'b1;
    bus.load_ch  = ch;
    bus.load_val = v;
  endtask

  task automatic unload();
    bus.load_en  = 1'b0;
    bus.load_ch  = '0;
    bus.load_val = '0;
  endtask

  logic [1:0] s2_tick [4] = '{2'b00, 2'b10, 2'b00, 2'b11};
  logic [1:0] s2_div  [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
  logic [1:0] s5_tick [4] = '{2'b00, 2'b01, 2'b00, 2'b10};
  logic [1:0] s5_div  [4] = '{2'b01, 2'b00, 2'b00, 2'b10};

  initial begin
    bus.ch_en  = '0;
    bus.sync   = 1'b0;
    bus3.ch_en = '0;
    bus3.sync  = 1'b0;
    bus3.load_en  = 1'b0;
    bus3.load_ch  = '0;
    bus3.load_val = '0;
    unload();

    repeat (3) step();
    check("rst_div",  32'(bus.divided_clk), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);
    check("rst_pend", 32'(bus.pending), 32'h0);
    check("rst3_out", 32'({bus3.divided_clk, bus3.tick}), 32'h0);

    rst        = 1'b0;
    bus.ch_en  = 2'b11;
    bus3.ch_en = 3'b111;

    // default divisor: tick every 4, divided clock period 8, in phase
    for (int k = 1; k <= 12; k++) begin
      step();
      check("s1_tick", 32'(bus.tick), (k % 4 == 0) ? 32'h3 : 32'h0);
      check("s1_div", 32'(bus.divided_clk),
            ((k / 4) % 2 == 1) ? 32'h3 : 32'h0);
      check("s1_pend", 32'(bus.pending), 32'h0);
    end

    // ch1 reload to 1 at cnt=1, pending until wrap
    step();
    load(1'b1, 8'd1);
    step();
    unload();
    check("s2_pend_a", 32'(bus.pending), 32'h2);
    check("s2_tick_a", 32'(bus.tick), 32'h0);
    step();
    check("s2_pend_b", 32'(bus.pending), 32'h2);
    step();
    check("s2_tick_w", 32'(bus.tick), 32'h3);
    check("s2_pend_w", 32'(bus.pending), 32'h0);
    check("s2_div_w", 32'(bus.divided_clk), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("s2_tick", 32'(bus.tick), 32'(s2_tick[k]));
      check("s2_div", 32'(bus.divided_clk), 32'(s2_div[k]));
    end

    // ch0 reload to 5 in the wrap cycle bypasses shadow
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check("s3_sync", 32'({bus.divided_clk, bus.tick}), 32'h0);
    repeat (3) step();
    load(1'b0, 8'd5);
    step();
    unload();
    check("s3_tick_w", 32'(bus.tick[0]), 32'h1);
    check("s3_pend_w", 32'(bus.pending), 32'h0);
    check("s3_div_w", 32'(bus.divided_clk[0]), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("s3_tick", 32'(bus.tick[0]), (k == 6) ? 32'h1 : 32'h0);
      check("s3_pend", 32'(bus.pending[0]), 32'h0);
    end
    check("s3_div", 32'(bus.divided_clk[0]), 32'h0);

    // ch0 reload to 0: commit at wrap then clk_in/2 and tick stuck high
    load(1'b0, 8'd0);
    step();
    unload();
    check("s4_pend_l", 32'(bus.pending[0]), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("s4_pend", 32'(bus.pending[0]), 32'h1);
      check("s4_tick0", 32'(bus.tick[0]), 32'h0);
    end
    step();
    check("s4_tick_w", 32'(bus.tick[0]), 32'h1);
    check("s4_pend_w", 32'(bus.pending[0]), 32'h0);
    check("s4_div_w", 32'(bus.divided_clk[0]), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("s4_tick", 32'(bus.tick[0]), 32'h1);
      check("s4_div", 32'(bus.divided_clk[0]), 32'(k % 2 == 0));
    end

    // restore T=3 on both: ch1 via shadow, ch0 via load+sync
    load(1'b1, 8'd3);
    step();
    load(1'b0, 8'd3);
    bus.sync = 1'b1;
    step();
    unload();
    bus.sync = 1'b0;
    check("s5_sync_p", 32'(bus.pending), 32'h0);
    check("s5_sync_o", 32'({bus.divided_clk, bus.tick}), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("s5_tick_r", 32'(bus.tick), (k == 4) ? 32'h3 : 32'h0);
    end
    check("s5_div_r", 32'(bus.divided_clk), 32'h3);

    // drop ch1 mid-count, then re-enable
    step();
    bus.ch_en = 2'b01;
    step();
    check("s5_dis_div", 32'(bus.divided_clk), 32'h1);
    check("s5_dis_tick", 32'(bus.tick), 32'h0);
    bus.ch_en = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check("s5_tick", 32'(bus.tick), 32'(s5_tick[k]));
      check("s5_div", 32'(bus.divided_clk), 32'(s5_div[k]));
    end

    // channels out of phase: sync realigns them
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    check("s6_sync", 32'({bus.divided_clk, bus.tick}), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("s6_tick", 32'(bus.tick), (k % 4 == 0) ? 32'h3 : 32'h0);
      check("s6_div", 32'(bus.divided_clk),
            ((k / 4) % 2 == 1) ? 32'h3 : 32'h0);
    end

    // out-of-range load_ch on the 3-channel instance is ignored
    bus3.sync = 1'b1;
    step();
    bus3.sync     = 1'b0;
    bus3.load_en  = 1'b1;
    bus3.load_ch  = 2'd3;
    bus3.load_val = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      step();
      bus3.load_en = 1'b0;
      check("s7_pend", 32'(bus3.pending), 32'h0);
      check("s7_tick", 32'(bus3.tick), (k % 4 == 0) ? 32'h7 : 32'h0);
    end

    // async reset mid-count drops the programmed value
    load(1'b0, 8'd1);
    step();
    unload();
    check("s8_pend_pre", 32'(bus.pending), 32'h1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("s8_rst_out",
          32'({bus.divided_clk, bus.tick, bus.pending}), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("s8_tick", 32'(bus.tick), (k % 4 == 0) ? 32'h3 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
